ram_port_arbiter: RTL and testbench

Shares the single read/write data port (port A) of the RAMIO block between two requesters: requester 0 is the CPU load/store path, requester 1 is the UART boot/debug loader that writes program images and reads back memory. Requester 0 has fixed priority, and a starvation counter guarantees requester 1 a slot after a bounded run of CPU accesses. Each cycle the arbiter drives at most one access to port A and routes the one-cycle-delayed read data back to the requester that issued the read.

---
 rtl/ram_port_arbiter.sv | 99 +++++++++
 tb/tb_ram_port_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter for RAMIO port A: fixed priority to requester 0, with a run counter that bounds requester 1 wait.
// Grant is combinational (0 cycles), read data is tagged to its owner 1 cycle later; losers simply hold their request.
module ram_port_arbiter #(
  parameter int ADDR_WIDTH = 15,
  parameter int MAX_RUN    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [1:0]            we0,
  input  logic [1:0]            we1,
  input  logic [2:0]            re0,
  input  logic [2:0]            re1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [31:0]           din0,
  input  logic [31:0]           din1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [31:0]           rdata,
  output logic [1:0]            ram_we,
  output logic [2:0]            ram_re,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_din,
  input  logic [31:0]           ram_dout,
  output logic                  starving
);

  localparam logic [7:0] RUN_MAX = 8'(MAX_RUN);

  logic       valid0;
  logic       valid1;
  logic [7:0] run_cnt;
  logic [7:0] run_cnt_next;

  // A request must name exactly one operation; anything else is dropped.
  assign valid0 = req0 && ((we0 != 2'b00) != (re0 != 3'b000));
  assign valid1 = req1 && ((we1 != 2'b00) != (re1 != 3'b000));

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst) begin
      if (starving && valid1) begin
        gnt1 = 1'b1;
      end else if (valid0) begin
        gnt0 = 1'b1;
      end else if (valid1) begin
        gnt1 = 1'b1;
      end
    end
  end

  always_comb begin
    ram_we   = '0;
    ram_re   = '0;
    ram_addr = '0;
    ram_din  = '0;
    if (gnt0) begin
      ram_we   = we0;
      ram_re   = re0;
      ram_addr = addr0;
      ram_din  = din0;
    end else if (gnt1) begin
      ram_we   = we1;
      ram_re   = re1;
      ram_addr = addr1;
      ram_din  = din1;
    end
  end

  // Counts requester-0 wins that happened while requester 1 was waiting.
  always_comb begin
    run_cnt_next = 8'd0;
    if (gnt0 && valid1) begin
      run_cnt_next = (run_cnt >= RUN_MAX) ? RUN_MAX : run_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_cnt  <= 8'd0;
      starving <= 1'b0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
    end else begin
      run_cnt  <= run_cnt_next;
      starving <= (run_cnt_next == RUN_MAX) && valid1;
      rvalid0  <= gnt0 && (re0 != 3'b000);
      rvalid1  <= gnt1 && (re1 != 3'b000);
    end
  end

  assign rdata = ram_dout;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: RAMIO port-A stub plus a grant/memory reference model, directed and random traffic.
module tb_ram_port_arbiter;
  localparam int AW = 15;
  localparam int MAX_RUN = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [1:0]    we0 = '0, we1 = '0;
  logic [2:0]    re0 = '0, re1 = '0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [31:0]   din0 = '0, din1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, starving;
  logic [31:0]   rdata, ram_din;
  logic [31:0]   ram_dout = '0;
  logic [1:0]    ram_we;
  logic [2:0]    ram_re;
  logic [AW-1:0] ram_addr;

  int errors = 0;
  int checks = 0;

  ram_port_arbiter #(.ADDR_WIDTH(AW), .MAX_RUN(MAX_RUN)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1), .re0(re0), .re1(re1),
    .addr0(addr0), .addr1(addr1), .din0(din0), .din1(din1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
    .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .starving(starving)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] extend(logic [31:0] w, logic [2:0] re);
    case (re[1:0])
      2'b01:   return re[2] ? {{24{w[7]}}, w[7:0]} : {24'b0, w[7:0]};
      2'b10:   return re[2] ? {{16{w[15]}}, w[15:0]} : {16'b0, w[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic int nbytes(logic [1:0] we);
    return (we == 2'b01) ? 1 : (we == 2'b10) ? 2 : 4;
  endfunction

  // RAMIO port-A stub: little-endian bytes, one-cycle read latency.
  logic [7:0] smem [32768];
  always @(posedge clk) begin
    if (ram_we != 2'b00)
      for (int i = 0; i < nbytes(ram_we); i++) smem[ram_addr + AW'(i)] <= ram_din[8*i +: 8];
    if (ram_re != 3'b000)
      ram_dout <= extend({smem[ram_addr + 15'd3], smem[ram_addr + 15'd2],
                          smem[ram_addr + 15'd1], smem[ram_addr]}, ram_re);
  end

  // Reference model state.
  logic [7:0]  rmem [32768];
  int          run = 0;
  bit          exp_starv = 0;
  bit [1:0]    exp_rv = '0;
  logic [31:0] exp_rdata = '0;
  int          last_win = 2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_valid(logic rq, logic [1:0] we, logic [2:0] re);
    return rq && ((we != 0) != (re != 0));
  endfunction

  task automatic model_write(input logic [AW-1:0] a, input logic [1:0] we, input logic [31:0] d);
    for (int i = 0; i < nbytes(we); i++) rmem[a + AW'(i)] = d[8*i +: 8];
  endtask

  function automatic logic [31:0] model_read(logic [AW-1:0] a, logic [2:0] re);
    return extend({rmem[a + 15'd3], rmem[a + 15'd2], rmem[a + 15'd1], rmem[a]}, re);
  endfunction

  // One cycle: inputs already driven at the negedge; check, predict, advance to next negedge.
  task automatic step();
    bit v0, v1;
    #1;
    v0 = is_valid(req0, we0, re0);
    v1 = is_valid(req1, we1, re1);
    last_win = (v1 && (exp_starv || !v0)) ? 1 : (v0 ? 0 : 2);
    chk("gnt0", gnt0, last_win == 0);
    chk("gnt1", gnt1, last_win == 1);
    chk("ram_we", ram_we, last_win == 0 ? we0 : last_win == 1 ? we1 : 2'b00);
    chk("ram_re", ram_re, last_win == 0 ? re0 : last_win == 1 ? re1 : 3'b000);
    chk("ram_addr", ram_addr, last_win == 0 ? addr0 : last_win == 1 ? addr1 : '0);
    chk("ram_din", ram_din, last_win == 0 ? din0 : last_win == 1 ? din1 : '0);
    chk("rvalid0", rvalid0, exp_rv[0]);
    chk("rvalid1", rvalid1, exp_rv[1]);
    chk("starving", starving, exp_starv);
    if (exp_rv != 0) chk("rdata", rdata, exp_rdata);
    exp_rv = '0;
    if (last_win == 0) begin
      if (we0 != 0) model_write(addr0, we0, din0);
      if (re0 != 0) begin exp_rv[0] = 1; exp_rdata = model_read(addr0, re0); end
    end else if (last_win == 1) begin
      if (we1 != 0) model_write(addr1, we1, din1);
      if (re1 != 0) begin exp_rv[1] = 1; exp_rdata = model_read(addr1, re1); end
    end
    run = (last_win == 0 && v1) ? ((run >= MAX_RUN) ? MAX_RUN : run + 1) : 0;
    exp_starv = (run == MAX_RUN);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set0(input logic rq, input logic [1:0] we, input logic [2:0] re,
                      input logic [AW-1:0] a, input logic [31:0] d);
    req0 = rq; we0 = we; re0 = re; addr0 = a; din0 = d;
  endtask

  task automatic set1(input logic rq, input logic [1:0] we, input logic [2:0] re,
                      input logic [AW-1:0] a, input logic [31:0] d);
    req1 = rq; we1 = we; re1 = re; addr1 = a; din1 = d;
  endtask

  task automatic rand_req(output logic rq, output logic [1:0] we, output logic [2:0] re,
                          output logic [AW-1:0] a, output logic [31:0] d);
    int kind, sz, off;
    rq   = ($urandom_range(0, 7) != 0);
    kind = $urandom_range(0, 9);
    sz   = $urandom_range(1, 3);
    off  = (sz == 1) ? $urandom_range(0, 3) : (sz == 2) ? 2 * $urandom_range(0, 1) : 0;
    a    = AW'(16'h0200 + 4 * $urandom_range(0, 15) + off);
    d    = $urandom;
    we   = 2'b00;
    re   = 3'b000;
    if (kind <= 3) we = 2'(sz);
    else if (kind <= 7) re = {1'($urandom_range(0, 1)), 2'(sz)};
    else if (kind == 8) begin we = 2'(sz); re = {1'b0, 2'(sz)}; end
  endtask

  initial begin
    // Reset state, with a valid request present: no grant, port idle.
    set0(1, 2'b11, 3'b000, 15'h0010, 32'h1234_5678);
    #12;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_rvalid0", rvalid0, 0);
    chk("rst_starving", starving, 0);
    set0(0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    step();

    // Requester-0 word write then word read.
    set0(1, 2'b11, 3'b000, 15'h0040, 32'hDEAD_BEEF);
    #1;
    chk("t1_gnt0", gnt0, 1);
    chk("t1_ram_we", ram_we, 2'b11);
    step();
    set0(1, 2'b00, 3'b111, 15'h0040, 32'h0);
    step();
    set0(0, 0, 0, 0, 0);
    chk("t1_rvalid0", rvalid0, 1);
    chk("t1_rdata", rdata, 32'hDEAD_BEEF);
    chk("t1_rvalid1", rvalid1, 0);
    step();

    // Full contention: period MAX_RUN+1 with requester 1 winning the last slot.
    for (int k = 0; k < 3 * (MAX_RUN + 1); k++) begin
      set0(1, 2'b11, 3'b000, AW'(16'h0300 + 4 * (k % 8)), 32'(k));
      set1(1, 2'b00, 3'b011, 15'h0040, 32'h0);
      #1;
      chk("cont_gnt1", gnt1, (k % (MAX_RUN + 1)) == MAX_RUN);
      step();
      chk("cont_starv", starving, (k % (MAX_RUN + 1)) == MAX_RUN - 1);
    end
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    step();

    // Loader-only burst: 16 writes then 16 reads, one per cycle.
    for (int i = 0; i < 16; i++) begin
      set1(1, 2'b11, 3'b000, AW'(4 * i), 32'hA500_0000 + 32'(i));
      step();
    end
    for (int i = 0; i < 16; i++) begin
      set1(1, 2'b00, 3'b011, AW'(4 * i), 32'h0);
      step();
      chk("ld_rvalid1", rvalid1, 1);
      chk("ld_rdata", rdata, 32'hA500_0000 + 32'(i));
    end
    set1(0, 0, 0, 0, 0);
    step();

    // Signed and unsigned byte reads of 0x80.
    set1(1, 2'b01, 3'b000, 15'h0101, 32'h0000_0080);
    step();
    set1(1, 2'b00, 3'b101, 15'h0101, 32'h0);
    step();
    chk("sx_rdata", rdata, 32'hFFFF_FF80);
    set1(1, 2'b00, 3'b001, 15'h0101, 32'h0);
    step();
    chk("zx_rdata", rdata, 32'h0000_0080);
    set1(0, 0, 0, 0, 0);
    step();

    // Invalid requester-0 request, alone and alongside a valid requester 1.
    set0(1, 2'b01, 3'b001, 15'h0044, 32'h0);
    #1;
    chk("inv_gnt0", gnt0, 0);
    chk("inv_ram_we", ram_we, 0);
    chk("inv_ram_re", ram_re, 0);
    step();
    set1(1, 2'b11, 3'b000, 15'h0048, 32'hCAFE_F00D);
    #1;
    chk("inv_gnt1", gnt1, 1);
    step();
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    step();

    // Reset in the cycle after a granted read drops the response.
    set0(1, 2'b00, 3'b011, 15'h0040, 32'h0);
    step();
    rst = 1'b0;
    #1;
    chk("mr_rvalid0", rvalid0, 0);
    chk("mr_gnt0", gnt0, 0);
    chk("mr_ram_re", ram_re, 0);
    run = 0; exp_starv = 0; exp_rv = '0;
    set0(0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    step();
    step();
    set0(1, 2'b00, 3'b011, 15'h0040, 32'h0);
    step();
    set0(0, 0, 0, 0, 0);
    chk("mr_after_rdata", rdata, 32'hDEAD_BEEF);
    step();

    // Random traffic: requesters hold valid requests until granted.
    for (int n = 0; n < 400; n++) begin
      if (!(is_valid(req0, we0, re0) && last_win != 0)) rand_req(req0, we0, re0, addr0, din0);
      if (!(is_valid(req1, we1, re1) && last_win != 1)) rand_req(req1, we1, re1, addr1, din1);
      step();
    end
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
